// File: rtl/fir_tx_pkg.sv
// Shared constants for the FIR output side: FSM encodings, default sizes and
// the sample period shared with the input side.
package fir_tx_pkg;

   typedef logic [1:0] tx_state_t;

   localparam tx_state_t ST_IDLE  = 2'd0;
   localparam tx_state_t ST_SHIFT = 2'd1;
   localparam tx_state_t ST_GAP   = 2'd2;

   localparam int DEF_DATA_WIDTH    = 16;
   localparam int DEF_FIFO_DEPTH    = 4;
   localparam int DEF_SCLK_HALF     = 4;
   localparam int DEF_CS_GAP        = 4;
   localparam int CYCLES_PER_SAMPLE = 2083;

   // Counter width able to hold 0..n-1, never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/fir_tx_fifo.sv
// Small synchronous first-word fall-through FIFO buffering filtered samples
// ahead of the SPI serializer. A write into a full FIFO succeeds if a pop
// happens in the same cycle.
module fir_tx_fifo
   import fir_tx_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          wr_en,
   input  logic [DATA_WIDTH-1:0]         wr_data,
   input  logic                          rd_en,
   output logic [DATA_WIDTH-1:0]         rd_data,
   output logic                          full,
   output logic                          empty,
   output logic [$clog2(FIFO_DEPTH):0]   level
);

   localparam int PTR_W = cnt_width(FIFO_DEPTH);
   localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
   localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

   logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0]      wr_ptr;
   logic [PTR_W-1:0]      rd_ptr;
   logic                  wr_ok;
   logic                  rd_ok;

   assign full    = (level == LVL_FULL);
   assign empty   = (level == '0);
   assign rd_ok   = rd_en && !empty;
   assign wr_ok   = wr_en && (!full || rd_ok);
   assign rd_data = mem[rd_ptr];

   // Pointers wrap naturally because the depth is a power of two.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
         if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
         if (wr_ok && !rd_ok)
            level <= level + LVL_W'(1);
         else if (!wr_ok && rd_ok)
            level <= level - LVL_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (wr_ok) mem[wr_ptr] <= wr_data;
   end

endmodule

// File: rtl/fir_dac_spi_tx.sv
// FIR output sink: buffers filtered samples and shifts each one MSB-first to
// an SPI audio DAC. Define FIR_TX_OFFSET_BINARY_EN to send offset binary.
module fir_dac_spi_tx
   import fir_tx_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
   parameter int SCLK_HALF  = DEF_SCLK_HALF,
   parameter int CS_GAP     = DEF_CS_GAP
) (
   input  logic                          sys_clk_100,
   input  logic                          rst,
   input  logic [DATA_WIDTH-1:0]         y_in,
   input  logic                          y_valid,
   output logic                          dac_cs_n,
   output logic                          dac_sclk,
   output logic                          dac_mosi,
   output logic                          busy,
   output logic                          overflow,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   localparam int BIT_W = $clog2(DATA_WIDTH);
   localparam int HC_W  = cnt_width(SCLK_HALF);
   localparam int GAP_W = cnt_width(CS_GAP);

   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);
   localparam logic [HC_W-1:0]  HC_LAST  = HC_W'(SCLK_HALF - 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CS_GAP - 1);

   tx_state_t             state;
   logic [HC_W-1:0]       half_cnt;
   logic [BIT_W-1:0]      bit_cnt;
   logic [GAP_W-1:0]      gap_cnt;
   logic [DATA_WIDTH-1:0] shreg;
   logic [DATA_WIDTH-1:0] load_word;
   logic [DATA_WIDTH-1:0] fifo_rd_data;
   logic                  fifo_rd_en;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic                  half_wrap;
   logic                  bit_advance;

   function automatic logic [DATA_WIDTH-1:0] tx_format(input logic [DATA_WIDTH-1:0] w);
`ifdef FIR_TX_OFFSET_BINARY_EN
      return {~w[DATA_WIDTH-1], w[DATA_WIDTH-2:0]};
`else
      return w;
`endif
   endfunction

   fir_tx_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (sys_clk_100),
      .rst     (rst),
      .wr_en   (y_valid),
      .wr_data (y_in),
      .rd_en   (fifo_rd_en),
      .rd_data (fifo_rd_data),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .level   (fifo_level)
   );

   assign fifo_rd_en  = (state == ST_IDLE) && !fifo_empty;
   assign load_word   = tx_format(fifo_rd_data);
   assign busy        = (state != ST_IDLE);
   assign half_wrap   = (state == ST_SHIFT) && (half_cnt == HC_LAST);
   // A falling SCLK edge that is not the end of the frame moves to the next bit.
   assign bit_advance = half_wrap && dac_sclk && (bit_cnt != BIT_LAST);

   always_ff @(posedge sys_clk_100 or posedge rst) begin
      if (rst) begin
         state    <= ST_IDLE;
         half_cnt <= '0;
         bit_cnt  <= '0;
         gap_cnt  <= '0;
         dac_cs_n <= 1'b1;
         dac_sclk <= 1'b0;
         dac_mosi <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (!fifo_empty) begin
                  state    <= ST_SHIFT;
                  half_cnt <= '0;
                  bit_cnt  <= '0;
                  dac_cs_n <= 1'b0;
                  dac_sclk <= 1'b0;
                  dac_mosi <= load_word[DATA_WIDTH-1];
               end
            end
            ST_SHIFT: begin
               if (half_cnt == HC_LAST) begin
                  half_cnt <= '0;
                  if (!dac_sclk) begin
                     dac_sclk <= 1'b1;
                  end else if (bit_cnt == BIT_LAST) begin
                     state    <= ST_GAP;
                     gap_cnt  <= '0;
                     dac_cs_n <= 1'b1;
                     dac_sclk <= 1'b0;
                     dac_mosi <= 1'b0;
                  end else begin
                     dac_sclk <= 1'b0;
                     bit_cnt  <= bit_cnt + 1'b1;
                     dac_mosi <= shreg[DATA_WIDTH-2];
                  end
               end else begin
                  half_cnt <= half_cnt + 1'b1;
               end
            end
            ST_GAP: begin
               if (gap_cnt == GAP_LAST)
                  state <= ST_IDLE;
               else
                  gap_cnt <= gap_cnt + 1'b1;
            end
            default: begin
               state    <= ST_IDLE;
               dac_cs_n <= 1'b1;
               dac_sclk <= 1'b0;
               dac_mosi <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge sys_clk_100 or posedge rst) begin
      if (rst)
         overflow <= 1'b0;
      else if (y_valid && fifo_full && !fifo_rd_en)
         overflow <= 1'b1;
   end

   always_ff @(posedge sys_clk_100) begin
      if (fifo_rd_en)
         shreg <= load_word;
      else if (bit_advance)
         shreg <= {shreg[DATA_WIDTH-2:0], 1'b0};
   end

endmodule

// File: tb/tb_fir_dac_spi_tx.sv
// Directed bench for fir_dac_spi_tx: a negedge SPI monitor records frames and
// inter-frame gaps; each scenario task compares against hand-derived values.
module tb_fir_dac_spi_tx;
   import fir_tx_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] y_in = '0;
   logic        y_valid = 1'b0;
   logic        dac_cs_n, dac_sclk, dac_mosi, busy, overflow;
   logic [2:0]  fifo_level;

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   fir_dac_spi_tx dut (
      .sys_clk_100 (clk),
      .rst         (rst),
      .y_in        (y_in),
      .y_valid     (y_valid),
      .dac_cs_n    (dac_cs_n),
      .dac_sclk    (dac_sclk),
      .dac_mosi    (dac_mosi),
      .busy        (busy),
      .overflow    (overflow),
      .fifo_level  (fifo_level)
   );

   // SPI monitor state
   logic [15:0] fr_data [64];
   int          fr_len   [64];
   int          fr_bits  [64];
   int          fr_first [64];
   int          gaps     [64];
   int          frame_n = 0;
   int          gap_n = 0;
   int          sclk_rises = 0;
   logic        in_frame = 1'b0;
   logic        have_rise = 1'b0;
   logic        prev_sclk = 1'b0;
   logic [15:0] cap = '0;
   int          nbits = 0;
   int          low_cnt = 0;
   int          first_rise = -1;
   int          hi_cnt = 0;

   always @(negedge clk) begin
      if (rst) begin
         in_frame  <= 1'b0;
         have_rise <= 1'b0;
         prev_sclk <= 1'b0;
      end else begin
         prev_sclk <= dac_sclk;
         if (!dac_cs_n) begin
            if (!in_frame) begin
               in_frame   <= 1'b1;
               cap        <= '0;
               nbits      <= 0;
               low_cnt    <= 1;
               first_rise <= -1;
               if (have_rise && gap_n < 64) begin
                  gaps[gap_n] <= hi_cnt;
                  gap_n       <= gap_n + 1;
               end
            end else begin
               low_cnt <= low_cnt + 1;
               if (dac_sclk && !prev_sclk) begin
                  if (nbits == 0) first_rise <= low_cnt;
                  cap        <= {cap[14:0], dac_mosi};
                  nbits      <= nbits + 1;
                  sclk_rises <= sclk_rises + 1;
               end
            end
         end else begin
            if (in_frame) begin
               if (frame_n < 64) begin
                  fr_data[frame_n]  <= cap;
                  fr_len[frame_n]   <= low_cnt;
                  fr_bits[frame_n]  <= nbits;
                  fr_first[frame_n] <= first_rise;
               end
               frame_n   <= frame_n + 1;
               in_frame  <= 1'b0;
               have_rise <= 1'b1;
               hi_cnt    <= 1;
            end else begin
               hi_cnt <= hi_cnt + 1;
            end
         end
      end
   end

   function automatic logic [15:0] wire_word(input logic [15:0] v);
`ifdef FIR_TX_OFFSET_BINARY_EN
      return v ^ 16'h8000;
`else
      return v;
`endif
   endfunction

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      y_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic send(input logic [15:0] v);
      @(negedge clk);
      y_in = v;
      y_valid = 1'b1;
      @(negedge clk);
      y_valid = 1'b0;
   endtask

   task automatic wait_frames(input int target, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(posedge clk);
         if (frame_n >= target) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      y_valid = 1'b0;
      repeat (3) @(negedge clk);
      n_total++; if (dac_cs_n !== 1'b1) $display("FAIL rst_cs_n: got %b want 1", dac_cs_n); else n_pass++;
      n_total++; if (dac_sclk !== 1'b0) $display("FAIL rst_sclk: got %b want 0", dac_sclk); else n_pass++;
      n_total++; if (dac_mosi !== 1'b0) $display("FAIL rst_mosi: got %b want 0", dac_mosi); else n_pass++;
      n_total++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else n_pass++;
      n_total++; if (overflow !== 1'b0) $display("FAIL rst_overflow: got %b want 0", overflow); else n_pass++;
      n_total++; if (fifo_level !== 3'd0) $display("FAIL rst_level: got %0d want 0", fifo_level); else n_pass++;
      rst = 1'b0;
      repeat (2) @(negedge clk);
      n_total++; if (dac_cs_n !== 1'b1 || busy !== 1'b0) $display("FAIL post_rst_idle: cs_n=%b busy=%b want 1/0", dac_cs_n, busy); else n_pass++;
   endtask

   task automatic test_single();
      int base;
      bit ok;
      logic [15:0] exp_w;
      exp_w = wire_word(16'h8001);
      base = frame_n;
      send(16'h8001);
      n_total++; if (fifo_level !== 3'd1) $display("FAIL single_wr_level: got %0d want 1", fifo_level); else n_pass++;
      n_total++; if (dac_cs_n !== 1'b1) $display("FAIL single_cs_early: got %b want 1", dac_cs_n); else n_pass++;
      @(negedge clk);
      n_total++; if (dac_cs_n !== 1'b0) $display("FAIL single_cs_fall: got %b want 0", dac_cs_n); else n_pass++;
      n_total++; if (dac_mosi !== exp_w[15]) $display("FAIL single_msb: got %b want %b", dac_mosi, exp_w[15]); else n_pass++;
      n_total++; if (busy !== 1'b1 || fifo_level !== 3'd0) $display("FAIL single_pop: busy=%b level=%0d want 1/0", busy, fifo_level); else n_pass++;
      wait_frames(base + 1, 400, ok);
      n_total++; if (!ok) $display("FAIL single_timeout: frames=%0d want %0d", frame_n - base, 1); else n_pass++;
      if (ok) begin
         n_total++; if (fr_data[base] !== exp_w) $display("FAIL single_data: got %h want %h", fr_data[base], exp_w); else n_pass++;
         n_total++; if (fr_len[base] != 128) $display("FAIL single_cs_len: got %0d want 128", fr_len[base]); else n_pass++;
         n_total++; if (fr_bits[base] != 16) $display("FAIL single_bits: got %0d want 16", fr_bits[base]); else n_pass++;
         n_total++; if (fr_first[base] != 4) $display("FAIL single_first_rise: got %0d want 4", fr_first[base]); else n_pass++;
      end
      repeat (10) @(negedge clk);
      n_total++; if (busy !== 1'b0) $display("FAIL single_idle: busy=%b want 0", busy); else n_pass++;
   endtask

   task automatic test_overflow();
      int base;
      bit ok;
      logic [15:0] exp_w;
      base = frame_n;
      for (int i = 1; i <= 6; i++) begin
         @(negedge clk);
         if (i == 6) begin
            n_total++; if (overflow !== 1'b0) $display("FAIL ovf_early: got %b want 0", overflow); else n_pass++;
            n_total++; if (fifo_level !== 3'd4) $display("FAIL ovf_full_level: got %0d want 4", fifo_level); else n_pass++;
         end
         y_in = 16'(i);
         y_valid = 1'b1;
      end
      @(negedge clk);
      y_valid = 1'b0;
      n_total++; if (overflow !== 1'b1) $display("FAIL ovf_set: got %b want 1", overflow); else n_pass++;
      n_total++; if (fifo_level !== 3'd4) $display("FAIL ovf_level: got %0d want 4", fifo_level); else n_pass++;
      wait_frames(base + 5, 1500, ok);
      n_total++; if (!ok) $display("FAIL ovf_timeout: frames=%0d want 5", frame_n - base); else n_pass++;
      if (ok) begin
         for (int k = 0; k < 5; k++) begin
            exp_w = wire_word(16'(k + 1));
            n_total++; if (fr_data[base + k] !== exp_w) $display("FAIL ovf_data%0d: got %h want %h", k, fr_data[base + k], exp_w); else n_pass++;
         end
      end
      repeat (300) @(posedge clk);
      n_total++; if (frame_n != base + 5) $display("FAIL ovf_frame_count: got %0d want 5", frame_n - base); else n_pass++;
      @(negedge clk);
      n_total++; if (overflow !== 1'b1) $display("FAIL ovf_sticky: got %b want 1", overflow); else n_pass++;
   endtask

   task automatic test_back_to_back();
      int base;
      int gbase;
      bit ok;
      logic [15:0] exp_a;
      logic [15:0] exp_b;
      exp_a = wire_word(16'h1234);
      exp_b = wire_word(16'h8000);
      do_reset();
      base  = frame_n;
      gbase = gap_n;
      @(negedge clk);
      y_in = 16'h1234;
      y_valid = 1'b1;
      @(negedge clk);
      y_in = 16'h8000;
      @(negedge clk);
      y_valid = 1'b0;
      wait_frames(base + 2, 600, ok);
      n_total++; if (!ok) $display("FAIL b2b_timeout: frames=%0d want 2", frame_n - base); else n_pass++;
      if (ok) begin
         n_total++; if (fr_data[base] !== exp_a) $display("FAIL b2b_data0: got %h want %h", fr_data[base], exp_a); else n_pass++;
         n_total++; if (fr_data[base + 1] !== exp_b) $display("FAIL b2b_data1: got %h want %h", fr_data[base + 1], exp_b); else n_pass++;
         n_total++; if (gap_n != gbase + 1) $display("FAIL b2b_gap_count: got %0d want 1", gap_n - gbase); else n_pass++;
         n_total++; if (gaps[gbase] != 5) $display("FAIL b2b_gap_len: got %0d want 5", gaps[gbase]); else n_pass++;
      end
   endtask

   task automatic test_realtime();
      int base;
      bit ok;
      bit lvl_bad;
      logic [15:0] vals [20];
      logic [15:0] exp_w;
      do_reset();
      base = frame_n;
      lvl_bad = 1'b0;
      for (int s = 0; s < 20; s++) begin
         vals[s] = 16'(s * 16'h0D2B + 16'h7F01);
         @(negedge clk);
         y_in = vals[s];
         y_valid = 1'b1;
         @(negedge clk);
         y_valid = 1'b0;
         for (int c = 2; c < CYCLES_PER_SAMPLE; c++) begin
            @(negedge clk);
            if (fifo_level > 3'd1) lvl_bad = 1'b1;
         end
      end
      wait_frames(base + 20, 400, ok);
      n_total++; if (!ok) $display("FAIL rt_timeout: frames=%0d want 20", frame_n - base); else n_pass++;
      if (ok) begin
         for (int s = 0; s < 20; s++) begin
            exp_w = wire_word(vals[s]);
            n_total++; if (fr_data[base + s] !== exp_w) $display("FAIL rt_data%0d: got %h want %h", s, fr_data[base + s], exp_w); else n_pass++;
         end
      end
      n_total++; if (lvl_bad) $display("FAIL rt_level: got >1 want <=1"); else n_pass++;
      n_total++; if (overflow !== 1'b0) $display("FAIL rt_overflow: got %b want 0", overflow); else n_pass++;
   endtask

   task automatic test_reset_midframe();
      int rbase;
      int base;
      bit ok;
      bit act;
      logic [15:0] exp_w;
      do_reset();
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         y_in = 16'hA5C0 + 16'(i);
         y_valid = 1'b1;
      end
      @(negedge clk);
      y_valid = 1'b0;
      rbase = sclk_rises;
      ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(posedge clk);
         if (sclk_rises >= rbase + 7) begin
            ok = 1'b1;
            break;
         end
      end
      n_total++; if (!ok) $display("FAIL mid_rise_timeout: rises=%0d want 7", sclk_rises - rbase); else n_pass++;
      #1 rst = 1'b1;
      #1;
      n_total++; if (dac_cs_n !== 1'b1) $display("FAIL mid_cs_n: got %b want 1", dac_cs_n); else n_pass++;
      n_total++; if (dac_sclk !== 1'b0) $display("FAIL mid_sclk: got %b want 0", dac_sclk); else n_pass++;
      n_total++; if (fifo_level !== 3'd0) $display("FAIL mid_level: got %0d want 0", fifo_level); else n_pass++;
      n_total++; if (overflow !== 1'b0) $display("FAIL mid_overflow: got %b want 0", overflow); else n_pass++;
      n_total++; if (busy !== 1'b0 || dac_mosi !== 1'b0) $display("FAIL mid_busy_mosi: busy=%b mosi=%b want 0/0", busy, dac_mosi); else n_pass++;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      base = frame_n;
      act = 1'b0;
      repeat (400) begin
         @(negedge clk);
         if (!dac_cs_n || dac_sclk || dac_mosi || busy) act = 1'b1;
      end
      n_total++; if (act) $display("FAIL mid_quiet: got activity want none"); else n_pass++;
      n_total++; if (frame_n != base) $display("FAIL mid_no_frame: got %0d want 0", frame_n - base); else n_pass++;
      exp_w = wire_word(16'h00F0);
      send(16'h00F0);
      wait_frames(base + 1, 400, ok);
      n_total++; if (!ok) $display("FAIL mid_recover_timeout: frames=%0d want 1", frame_n - base); else n_pass++;
      if (ok) begin
         n_total++; if (fr_data[base] !== exp_w) $display("FAIL mid_recover_data: got %h want %h", fr_data[base], exp_w); else n_pass++;
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single();
      test_overflow();
      test_back_to_back();
      test_realtime();
      test_reset_midframe();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
